ram_tile_reader: RTL and testbench
==================================

// Module: ram_tile_reader
// PURPOSE
//  Read-side initiator for one read port of the unified multi-port RAM (combinational read:
//  q is valid in the same cycle as addr). Walks a ROWS x COLS tile starting at base address
//  with a row stride and streams the words out over valid/ready, buffered in a small FIFO.
//  Feeds matmul/GPU datapaths from A/B matrix regions without them driving RAM addresses.
// PARAMETERS
//  ADDR_W      32  RAM address width; address arithmetic wraps modulo 2^ADDR_W
//  DATA_W      32  RAM word width
//  DIM_W       16  width of rows/cols/stride operands
//  FIFO_DEPTH  2   output buffer entries (>=2); sustains 1 word/cycle at ready=1
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       synchronous active-low reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_W  address of element (0,0)
//  rows       in   DIM_W   tile rows
//  cols       in   DIM_W   tile columns (words per row)
//  stride     in   DIM_W   address step between row starts
//  mem_addr   out  ADDR_W  to RAM addrN
//  mem_q      in   DATA_W  from RAM qN (combinational on mem_addr)
//  mem_we     out  1       tied 0 (reader never writes)
//  out_data   out  DATA_W  FIFO head word
//  out_valid  out  1       FIFO non-empty
//  out_ready  in   1       consumer accepts when valid&ready at clock edge
//  out_last   out  1       head word is final element of tile
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse at end of tile
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE, FIFO flushed, row/col counters 0, mem_addr=0,
//   out_valid=0, out_last=0, busy=0, done=0. Applies mid-tile: tile abandoned, nothing resumes.
//  States: IDLE -> READ (start, rows!=0, cols!=0; operands latched)
//          IDLE -> IDLE with done=1 next cycle (start with rows==0 or cols==0; no output)
//          READ -> DRAIN when final element captured; DRAIN -> IDLE on final pop.
//  mem_addr = row_base + col (combinational from regs); row_base=base_addr at start,
//   += stride at end of each row; col 0..cols-1. Row-major order, no bounds check vs RAM LEN.
//  Read issue in READ: capture mem_q into FIFO tail at edge when count<FIFO_DEPTH, or
//   count==FIFO_DEPTH and a pop occurs same edge. Otherwise address/counters hold.
//  Simultaneous push+pop: count unchanged, order preserved. Pop only when out_valid&out_ready.
//  Latency: start sampled at edge 0 -> mem_addr=base at cycle 1 -> out_valid at cycle 2.
//  Throughput: 1 word/cycle with out_ready held 1.
//  out_last travels with the word as a FIFO tag bit; set only on element (rows-1,cols-1).
//  done asserts the cycle after the final handshake (state back in IDLE); busy low same cycle.
//  start while busy: ignored, no effect on operands or stream.
//  out_data/out_last undefined-but-stable-0 when out_valid=0 (drive 0).
// TESTING
//  T1 mem[a]=a; base=2048 rows=2 cols=3 stride=4, ready=1 -> out 2048,2049,2050,2052,2053,2054
//     on consecutive cycles from start+2, out_last only on 2054, done at start+8.
//  T2 same tile, out_ready=0 for cycles 2..6 -> out_valid held, exactly 2 words buffered,
//     mem_addr holds at 2050; resume yields identical sequence, no loss/duplication.
//  T3 rows=0 cols=5 start -> done=1 next cycle, out_valid never asserts, busy stays 0.
//  T4 start pulsed again mid-tile with base=4096 -> ignored, T1 sequence unchanged.
//  T5 reset_n=0 after 3rd word of T1 -> next cycle out_valid=0 busy=0 mem_addr=0; new start
//     base=6144 rows=1 cols=2 -> 6144,6145 with last on 6145.
//  T6 base=32'hFFFF_FFFE rows=1 cols=4 -> mem_addr FFFF_FFFE,FFFF_FFFF,0,1 (wrap).

Source files
------------

// File: rtl/ram_tile_reader.sv
// Purpose : generic first-word-fall-through FIFO; head_dat is the oldest entry whenever count != 0.
// Latency : a pushed word is visible at the head on the cycle after the push edge.
// Backpres: caller must not push when full unless it pops on the same edge, and must not pop when empty.
// Ports   : clock, reset_n (sync, active-low), push/push_dat, pop, head_dat, count.
module tile_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; count alone decides whether the head is meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose : walks a rows x cols tile (row stride apart) through a combinational RAM read port and
//           streams the words out over valid/ready, tagging the final element with out_last.
// Latency : start sampled at edge 0 -> mem_addr = base in cycle 1 -> first out_valid in cycle 2; 1 word/cycle.
// Backpres: reads stall (address and counters hold) while the output FIFO is full and not popping.
// Ports   : clock, reset_n (sync, active-low), start/base_addr/rows/cols/stride request,
//           mem_addr/mem_q/mem_we RAM port, out_data/out_valid/out_ready/out_last stream, busy, done.
module ram_tile_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DIM_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DIM_W-1:0]  stride,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              mem_we,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] row_base;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  rows_q;
    logic [DIM_W-1:0]  cols_q;
    logic [DIM_W-1:0]  stride_q;
    logic              done_q;

    logic [CNT_W-1:0]  fifo_cnt;
    logic [DATA_W:0]   head_dat;   // {last tag, data word}
    logic              fifo_vld;
    logic              push;
    logic              pop;
    logic              end_of_row;
    logic              last_elem;
    logic              start_ok;

    assign mem_we     = 1'b0;
    assign mem_addr   = row_base + ADDR_W'(col);
    assign fifo_vld   = (fifo_cnt != '0);
    assign pop        = fifo_vld && out_ready;
    // A full FIFO still accepts a read on an edge where the head leaves.
    assign push       = (state == READ) && ((fifo_cnt < CNT_W'(FIFO_DEPTH)) || pop);
    assign end_of_row = (col == cols_q - DIM_W'(1));
    assign last_elem  = end_of_row && (row == rows_q - DIM_W'(1));
    assign start_ok   = (rows != '0) && (cols != '0);

    assign out_valid = fifo_vld;
    assign out_data  = fifo_vld ? head_dat[DATA_W-1:0] : '0;
    assign out_last  = fifo_vld && head_dat[DATA_W];
    assign busy      = (state != IDLE);
    assign done      = done_q;

    tile_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat ({last_elem, mem_q}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && start_ok) state_nxt = READ;
            READ:    if (push && last_elem) state_nxt = DRAIN;
            DRAIN:   if (pop && head_dat[DATA_W]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_base <= '0;
            row      <= '0;
            col      <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            stride_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            row_base <= base_addr;
                            row      <= '0;
                            col      <= '0;
                            rows_q   <= rows;
                            cols_q   <= cols;
                            stride_q <= stride;
                        end else begin
                            // Empty tile: report completion without producing any output.
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (push) begin
                        if (end_of_row) begin
                            col      <= '0;
                            row      <= row + DIM_W'(1);
                            row_base <= row_base + ADDR_W'(stride_q);
                        end else begin
                            col <= col + DIM_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_dat[DATA_W]) begin
                        done_q   <= 1'b1;
                        row_base <= '0;   // park the RAM address at 0 while idle
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_tile_reader.sv
// Purpose : directed self-checking bench for ram_tile_reader against a RAM model with mem[a] = a.
// Latency : all checks sample 1 time unit after the rising edge; inputs change at the same point.
// Backpres: out_ready is held high except in the stall test, which holds it low for cycles 2..6.
module tb_ram_tile_reader;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [15:0] stride;
    logic [31:0] mem_addr;
    logic [31:0] mem_q;
    logic        mem_we;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    // RAM model: every word holds its own address.
    assign mem_q = mem_addr;

    ram_tile_reader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .rows      (rows),
        .cols      (cols),
        .stride    (stride),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .mem_we    (mem_we),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one tile with out_ready=1 and checks the stream against exp_q, one word per cycle
    // from cycle 2. pulse_at: cycle at which a competing start (base 4096) is pulsed.
    // reset_at: cycle at which reset is applied instead of checking the word due then.
    task automatic run_tile(input logic [31:0] b, input logic [15:0] r, input logic [15:0] c,
                            input logic [15:0] s, input int pulse_at, input int reset_at);
        int cyc;
        base_addr = b; rows = r; cols = c; stride = s;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        chk("first_addr", mem_addr, b);
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("no_valid_c1", {31'd0, out_valid}, 32'd0);
        step();
        cyc = 2;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cyc == reset_at) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
                chk("rst_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_addr", mem_addr, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                step();
                chk("rst_idle_valid", {31'd0, out_valid}, 32'd0);
                return;
            end
            chk($sformatf("valid[%0d]", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("data[%0d]", i), out_data, exp_q[i]);
            chk($sformatf("last[%0d]", i), {31'd0, out_last}, (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
            chk($sformatf("busy[%0d]", i), {31'd0, busy}, 32'd1);
            if (cyc == pulse_at) begin
                base_addr = 32'd4096;
                rows      = 16'd5;
                start     = 1'b1;
            end
            step();
            start = 1'b0;
            base_addr = b; rows = r;
            cyc++;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("valid_end", {31'd0, out_valid}, 32'd0);
        step();
        chk("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        base_addr = '0; rows = '0; cols = '0; stride = '0;
        step();
        step();
        reset_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy0", {31'd0, busy}, 32'd0);
        chk("rst_done0", {31'd0, done}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("mem_we", {31'd0, mem_we}, 32'd0);

        // T1: 2x3 tile, stride 4.
        exp_q = '{32'd2048, 32'd2049, 32'd2050, 32'd2052, 32'd2053, 32'd2054};
        run_tile(32'd2048, 16'd2, 16'd3, 16'd4, 0, 0);

        // T2: consumer stalls for cycles 2..6.
        base_addr = 32'd2048; rows = 16'd2; cols = 16'd3; stride = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        step();
        chk("t2_c2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_c2_data", out_data, 32'd2048);
        chk("t2_c2_addr", mem_addr, 32'd2049);
        for (int c = 3; c <= 6; c++) begin
            step();
            chk($sformatf("t2_c%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t2_c%0d_data", c), out_data, 32'd2048);
            chk($sformatf("t2_c%0d_addr", c), mem_addr, 32'd2050);
        end
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t2_data[%0d]", i), out_data, exp_q[i]);
            chk($sformatf("t2_last[%0d]", i), {31'd0, out_last}, (i == 5) ? 32'd1 : 32'd0);
            step();
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        step();

        // T3: zero-row tile completes immediately with no output.
        base_addr = 32'd100; rows = 16'd0; cols = 16'd5; stride = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_valid", {31'd0, out_valid}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("t3_idle_valid%0d", c), {31'd0, out_valid}, 32'd0);
            chk($sformatf("t3_idle_busy%0d", c), {31'd0, busy}, 32'd0);
            chk($sformatf("t3_idle_done%0d", c), {31'd0, done}, 32'd0);
        end

        // T4: start pulsed mid-tile is ignored.
        run_tile(32'd2048, 16'd2, 16'd3, 16'd4, 4, 0);

        // T5: reset after the third word, then a fresh 1x2 tile.
        run_tile(32'd2048, 16'd2, 16'd3, 16'd4, 0, 5);
        exp_q = '{32'd6144, 32'd6145};
        run_tile(32'd6144, 16'd1, 16'd2, 16'd1, 0, 0);

        // T6: address wraps past 2^32.
        exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        run_tile(32'hFFFF_FFFE, 16'd1, 16'd4, 16'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
